bus_sequencer: RTL and testbench
================================

# bus_sequencer

Parametrised bus-timing sequencer that time-slices the shared CPU/RAM/IO bus between the Wishbone port and the W65C02S. It is the next generation of the fixed 64-cycle slot generator in `system`, which it replaces inside that module. It adds three things the fixed generator lacks: ns-parameterised slot derivation, a run-time selectable CPU speed (period length), and a CPU-halt mode that gives an entire period to Wishbone. Its outputs drive BE, Phi2, RAM/IO strobe qualification, Wishbone admission and FPGA address-output enable.

## Interface
- `SYS_CLOCK_MHZ`, 64, system clock frequency used for ns→cycle conversion
- `WB_DRAIN_CYCLES`, 5, max cycles for an in-flight Wishbone RAM transaction to complete
- `T_BVD_NS`, 30, CPU BE to valid bus
- `T_PWH_NS`, 62, minimum Phi2 high width
- `T_DSR_NS`, 15, CPU data setup
- `T_DH_NS`, 10, CPU data/BE hold
- `T_IO_NS`, 11, max(IO transceiver tPZL, RAM tAA)
- `COUNTER_WIDTH`, 7, must hold the longest period (128)
- `wb_clock_i` in 1 system clock; the only clock
- `wb_reset_i` in 1 synchronous, active-high reset
- `cpu_speed_i` in 2 00=1 MHz (64-cycle period), 01=2 MHz (32), 10=500 kHz (128), 11=reserved, treated as 00
- `cpu_halt_i` in 1 request to skip the CPU window of the next period
- `wb_ready_o` out 1 Wishbone requests may be admitted
- `cpu_be_o` out 1 CPU bus enable
- `bus_valid_o` out 1 CPU addr/RWB/DOUT valid; address decode may be sampled
- `io_valid_o` out 1 RAM access / IO transceiver delay met; qualifies chip selects
- `cpu_clock_o` out 1 Phi2
- `cpu_we_window_o` out 1 window in which a CPU RAM write strobe is permitted (equal to Phi2 high)
- `wb_addr_oe_o` out 1 FPGA drives the address bus
- `period_start_o` out 1 single-cycle pulse when the counter is 0
- `cpu_cycle_o` out 1 the current period contains a CPU window (latched halt inverted)

## Operation
- Slot offset from an ns value t: c(t) = ceil(t / (1000/SYS_CLOCK_MHZ)) + 1.
- Slot values (64 MHz defaults in brackets):
  - BE_START = WB_DRAIN [5]
  - BUS_VALID = BE_START + c(T_BVD) [8]
  - IO_VALID = BUS_VALID + c(T_IO) [10]
  - PHI_START = IO_VALID + c(T_DSR) [12]
  - PHI_END = PHI_START + c(T_PWH) [17]
  - BE_END = PHI_END + c(T_DH) [19]
  - WB_BE = BE_END + c(T_BVD) [22]
  - WB_READY = WB_BE + 1 [23]
- Elaboration-time check: WB_READY < 32 (the shortest period). `$fatal` if violated.
- Counter counts 0..P-1, then wraps to 0. P is taken from the latched speed.
- At counter == P-1, `active_speed` ← `cpu_speed_i` and `active_halt` ← `cpu_halt_i`. Both are held for the whole next period. Mid-period changes have no effect.
- CPU period (`active_halt` = 0). Registered updates on the edge where the counter equals the slot:
  - 0: wb_ready=0
  - BE_START: cpu_be=1, wb_addr_oe=0
  - BUS_VALID: bus_valid=1
  - IO_VALID: io_valid=1
  - PHI_START: cpu_clock=1, we_window=1
  - PHI_END: cpu_clock=0, we_window=0
  - BE_END: cpu_be=0, bus_valid=0, io_valid=0
  - WB_BE: wb_addr_oe=1
  - WB_READY: wb_ready=1
- Halted period (`active_halt` = 1): cpu_be, bus_valid, io_valid, cpu_clock and we_window stay 0. wb_addr_oe and wb_ready stay 1 for the whole period, including slot 0. Phi2 stays low; the W65C02S is static, so this is legal.
- Halt → run transition: the normal slot-0 deassert of wb_ready applies, and the drain window is preserved.
- cpu_be and wb_addr_oe are never both 1.

## Timing
- Every output is a flop. An output changes exactly one cycle after the counter matches its slot. There are no combinational paths from the inputs.
- `period_start_o` is high while counter == 0.
- `cpu_cycle_o` changes coincident with the counter wrapping to 0.
- Reset (synchronous): counter=0, active_speed=00, active_halt=0. Every output is 0 on the cycle after `wb_reset_i` is sampled high.
  - Reset mid-Phi2: Phi2 falls at once. The truncated pulse is accepted.
- First cycle after reset release: counter = 0, and a normal CPU period begins.
- Period P=32 leaves Wishbone 9 ready cycles (23..31). P=64 leaves 41. P=128 leaves 105.

## Structure
- `common_pkg` additions:
  - `cpu_speed_t` enum
  - `ns_to_cycles()` function, moved out of `system`
  - `period_len(cpu_speed_t)` function
- Sub-module `period_counter`: wrap counter plus speed/halt latch. Outputs are count and `active_halt`.
- `bus_sequencer`: slot compare and output registers.
- `system` instantiates `bus_sequencer` and drops its local slot logic.

## Test plan
- Reset values: hold reset 3 cycles mid-period → all outputs 0. After release, cpu_be rises on cycle 6 and cpu_clock is high for cycles 13–17.
- 1 MHz steady state: period_start every 64 cycles. cpu_clock high exactly 5 cycles per period. wb_ready high for cycles 24..63 and 0 of each period.
- 2 MHz: speed=01 → period_start spacing 32. Slot positions are identical to 1 MHz. wb_ready is high for 9 cycles per period.
- Mid-period speed change: switch 00→10 at counter 30 → the current period still ends at 64. The next period lasts 128.
- Halt: assert cpu_halt_i before a boundary → the next period has cpu_be=0, Phi2=0, and wb_ready=1 for all 64 cycles. Deassert it → the following period drops wb_ready at slot 0 and runs the CPU normally.
- Invariants (checked every cycle): cpu_be && wb_addr_oe never true; io_valid implies bus_valid; cpu_clock implies cpu_be.

Source files
------------

// File: rtl/bus_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bus_sequencer_pkg
// Description : Shared types and helpers for the CPU/Wishbone bus sequencer:
//               CPU speed encoding, ns-to-slot conversion and period lengths.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package bus_sequencer_pkg;

   // Run-time CPU speed selection; the reserved code behaves like 1 MHz
   typedef enum logic [1:0] {
      SPEED_1MHZ   = 2'b00,
      SPEED_2MHZ   = 2'b01,
      SPEED_500KHZ = 2'b10,
      SPEED_RSVD   = 2'b11
   } cpu_speed_t;

   // Shortest period any speed can select; every slot must fit inside it
   localparam int c_SHORTEST_PERIOD = 32;

   // Slot offset for an ns delay: whole cycles rounded up, plus one cycle of
   // margin for the registered output stage
   function automatic int ns_to_cycles(input int t_ns, input int clk_mhz);
      return ((t_ns * clk_mhz) + 999) / 1000 + 1;
   endfunction

   // Period length in system clocks for a given CPU speed
   function automatic int period_len(input cpu_speed_t speed);
      case (speed)
         SPEED_2MHZ:   return 32;
         SPEED_500KHZ: return 128;
         default:      return 64;
      endcase
   endfunction

endpackage : bus_sequencer_pkg
`default_nettype wire

// File: rtl/bus_sequencer_period_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : period_counter
// Description : Wrapping slot counter. Speed and halt requests are latched on
//               the last cycle of a period and held for the whole next period.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module period_counter
   import bus_sequencer_pkg::*;
#(
   parameter int COUNTER_WIDTH = 7
) (
   input  logic                     wb_clock_i,
   input  logic                     wb_reset_i,
   input  logic [1:0]               cpu_speed_i,
   input  logic                     cpu_halt_i,
   output logic [COUNTER_WIDTH-1:0] count_o,
   output logic                     period_end_o,
   output logic                     active_halt_o
);

   cpu_speed_t               r_speed;
   logic                     r_halt;
   logic [COUNTER_WIDTH-1:0] r_count;
   logic [COUNTER_WIDTH-1:0] w_last_slot;

   assign w_last_slot   = COUNTER_WIDTH'(period_len(r_speed) - 1);
   assign period_end_o  = (r_count == w_last_slot);
   assign count_o       = r_count;
   assign active_halt_o = r_halt;

   // Count through the period; sample the next period's speed/halt at the wrap
   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_i) begin
         r_count <= '0;
         r_speed <= SPEED_1MHZ;
         r_halt  <= 1'b0;
      end else if (period_end_o) begin
         r_count <= '0;
         r_speed <= cpu_speed_t'(cpu_speed_i);
         r_halt  <= cpu_halt_i;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule : period_counter
`default_nettype wire

// File: rtl/bus_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bus_sequencer
// Description : Time-slices the shared bus between Wishbone and the W65C02S.
//               Slot positions are derived from ns timing parameters; every
//               output is registered one cycle after its slot is reached.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module bus_sequencer
   import bus_sequencer_pkg::*;
#(
   parameter int SYS_CLOCK_MHZ   = 64,
   parameter int WB_DRAIN_CYCLES = 5,
   parameter int T_BVD_NS        = 30,
   parameter int T_PWH_NS        = 62,
   parameter int T_DSR_NS        = 15,
   parameter int T_DH_NS         = 10,
   parameter int T_IO_NS         = 11,
   parameter int COUNTER_WIDTH   = 7
) (
   input  logic       wb_clock_i,
   input  logic       wb_reset_i,
   input  logic [1:0] cpu_speed_i,
   input  logic       cpu_halt_i,
   output logic       wb_ready_o,
   output logic       cpu_be_o,
   output logic       bus_valid_o,
   output logic       io_valid_o,
   output logic       cpu_clock_o,
   output logic       cpu_we_window_o,
   output logic       wb_addr_oe_o,
   output logic       period_start_o,
   output logic       cpu_cycle_o
);

   // Slot chain: each event follows the previous one by its converted delay
   localparam int c_BE_START  = WB_DRAIN_CYCLES;
   localparam int c_BUS_VALID = c_BE_START  + ns_to_cycles(T_BVD_NS, SYS_CLOCK_MHZ);
   localparam int c_IO_VALID  = c_BUS_VALID + ns_to_cycles(T_IO_NS,  SYS_CLOCK_MHZ);
   localparam int c_PHI_START = c_IO_VALID  + ns_to_cycles(T_DSR_NS, SYS_CLOCK_MHZ);
   localparam int c_PHI_END   = c_PHI_START + ns_to_cycles(T_PWH_NS, SYS_CLOCK_MHZ);
   localparam int c_BE_END    = c_PHI_END   + ns_to_cycles(T_DH_NS,  SYS_CLOCK_MHZ);
   localparam int c_WB_BE     = c_BE_END    + ns_to_cycles(T_BVD_NS, SYS_CLOCK_MHZ);
   localparam int c_WB_READY  = c_WB_BE + 1;

   localparam logic [COUNTER_WIDTH-1:0] c_S_ZERO      = '0;
   localparam logic [COUNTER_WIDTH-1:0] c_S_BE_START  = COUNTER_WIDTH'(c_BE_START);
   localparam logic [COUNTER_WIDTH-1:0] c_S_BUS_VALID = COUNTER_WIDTH'(c_BUS_VALID);
   localparam logic [COUNTER_WIDTH-1:0] c_S_IO_VALID  = COUNTER_WIDTH'(c_IO_VALID);
   localparam logic [COUNTER_WIDTH-1:0] c_S_PHI_START = COUNTER_WIDTH'(c_PHI_START);
   localparam logic [COUNTER_WIDTH-1:0] c_S_PHI_END   = COUNTER_WIDTH'(c_PHI_END);
   localparam logic [COUNTER_WIDTH-1:0] c_S_BE_END    = COUNTER_WIDTH'(c_BE_END);
   localparam logic [COUNTER_WIDTH-1:0] c_S_WB_BE     = COUNTER_WIDTH'(c_WB_BE);
   localparam logic [COUNTER_WIDTH-1:0] c_S_WB_READY  = COUNTER_WIDTH'(c_WB_READY);

   // The whole CPU window must fit in the shortest (2 MHz) period
   if (c_WB_READY >= c_SHORTEST_PERIOD) begin : g_slot_check
      $fatal(1, "bus_sequencer: WB_READY slot %0d does not fit a %0d-cycle period",
             c_WB_READY, c_SHORTEST_PERIOD);
   end

   logic [COUNTER_WIDTH-1:0] w_count;
   logic                     w_period_end;
   logic                     w_active_halt;

   logic r_wb_ready, r_cpu_be, r_bus_valid, r_io_valid, r_cpu_clock;
   logic r_we_window, r_wb_addr_oe, r_period_start, r_cpu_cycle;

   period_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_period_counter (
      .wb_clock_i    (wb_clock_i),
      .wb_reset_i    (wb_reset_i),
      .cpu_speed_i   (cpu_speed_i),
      .cpu_halt_i    (cpu_halt_i),
      .count_o       (w_count),
      .period_end_o  (w_period_end),
      .active_halt_o (w_active_halt)
   );

   // Slot compare and output registers; a halted period hands the bus to Wishbone
   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_i) begin
         r_wb_ready     <= 1'b0;
         r_cpu_be       <= 1'b0;
         r_bus_valid    <= 1'b0;
         r_io_valid     <= 1'b0;
         r_cpu_clock    <= 1'b0;
         r_we_window    <= 1'b0;
         r_wb_addr_oe   <= 1'b0;
         r_period_start <= 1'b0;
         r_cpu_cycle    <= 1'b0;
      end else begin
         // Both track the counter wrap, so they line up with count 0
         r_period_start <= w_period_end;
         r_cpu_cycle    <= w_period_end ? ~cpu_halt_i : ~w_active_halt;

         if (w_active_halt) begin
            r_cpu_be     <= 1'b0;
            r_bus_valid  <= 1'b0;
            r_io_valid   <= 1'b0;
            r_cpu_clock  <= 1'b0;
            r_we_window  <= 1'b0;
            r_wb_addr_oe <= 1'b1;
            r_wb_ready   <= 1'b1;
         end else begin
            if (w_count == c_S_ZERO) begin
               r_wb_ready <= 1'b0;
            end
            if (w_count == c_S_BE_START) begin
               r_cpu_be     <= 1'b1;
               r_wb_addr_oe <= 1'b0;
            end
            if (w_count == c_S_BUS_VALID) begin
               r_bus_valid <= 1'b1;
            end
            if (w_count == c_S_IO_VALID) begin
               r_io_valid <= 1'b1;
            end
            if (w_count == c_S_PHI_START) begin
               r_cpu_clock <= 1'b1;
               r_we_window <= 1'b1;
            end
            if (w_count == c_S_PHI_END) begin
               r_cpu_clock <= 1'b0;
               r_we_window <= 1'b0;
            end
            if (w_count == c_S_BE_END) begin
               r_cpu_be    <= 1'b0;
               r_bus_valid <= 1'b0;
               r_io_valid  <= 1'b0;
            end
            if (w_count == c_S_WB_BE) begin
               r_wb_addr_oe <= 1'b1;
            end
            if (w_count == c_S_WB_READY) begin
               r_wb_ready <= 1'b1;
            end
         end
      end
   end

   assign wb_ready_o      = r_wb_ready;
   assign cpu_be_o        = r_cpu_be;
   assign bus_valid_o     = r_bus_valid;
   assign io_valid_o      = r_io_valid;
   assign cpu_clock_o     = r_cpu_clock;
   assign cpu_we_window_o = r_we_window;
   assign wb_addr_oe_o    = r_wb_addr_oe;
   assign period_start_o  = r_period_start;
   assign cpu_cycle_o     = r_cpu_cycle;

endmodule : bus_sequencer
`default_nettype wire

// File: tb/tb_bus_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_bus_sequencer
// Description : Self-checking bench for bus_sequencer. A period-level model
//               predicts every output from the counter position, period
//               length and halt state; directed phases pin the model with
//               hand-computed cycle numbers, then random stimulus runs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bus_sequencer;

   logic       clk;
   logic       rst;
   logic [1:0] cpu_speed_i;
   logic       cpu_halt_i;
   logic       wb_ready_o, cpu_be_o, bus_valid_o, io_valid_o, cpu_clock_o;
   logic       cpu_we_window_o, wb_addr_oe_o, period_start_o, cpu_cycle_o;

   int n_tests = 0;
   int n_fail  = 0;

   bus_sequencer u_dut (
      .wb_clock_i      (clk),
      .wb_reset_i      (rst),
      .cpu_speed_i     (cpu_speed_i),
      .cpu_halt_i      (cpu_halt_i),
      .wb_ready_o      (wb_ready_o),
      .cpu_be_o        (cpu_be_o),
      .bus_valid_o     (bus_valid_o),
      .io_valid_o      (io_valid_o),
      .cpu_clock_o     (cpu_clock_o),
      .cpu_we_window_o (cpu_we_window_o),
      .wb_addr_oe_o    (wb_addr_oe_o),
      .period_start_o  (period_start_o),
      .cpu_cycle_o     (cpu_cycle_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [8:0] w_dut = {wb_ready_o, cpu_be_o, bus_valid_o, io_valid_o, cpu_clock_o,
                       cpu_we_window_o, wb_addr_oe_o, period_start_o, cpu_cycle_o};

   // Reference model: position inside the period, period length, halt flag
   bit m_valid   = 1'b0;
   bit m_rst_cyc = 1'b0;
   bit m_first   = 1'b0;
   bit m_halt    = 1'b0;
   int m_count   = 0;
   int m_len     = 64;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b1; m_rst_cyc = 1'b1; m_first = 1'b1;
         m_halt = 1'b0; m_count = 0; m_len = 64;
      end else if (m_valid) begin
         m_rst_cyc = 1'b0;
         if (m_count == m_len - 1) begin
            m_count = 0;
            m_first = 1'b0;
            m_halt  = cpu_halt_i;
            m_len   = (cpu_speed_i == 2'b01) ? 32 : (cpu_speed_i == 2'b10) ? 128 : 64;
         end else begin
            m_count++;
         end
      end
   end

   // Expected outputs as windows over the period position (64 MHz defaults)
   function automatic logic [8:0] expect_out();
      int  k;
      logic rdy, be, bv, io, phi, oe;
      k = m_count;
      if (m_rst_cyc) return 9'b0;
      if (m_halt) return {1'b1, 5'b0, 1'b1, (k == 0), 1'b0};
      be  = (k >= 6)  && (k <= 19);
      bv  = (k >= 9)  && (k <= 19);
      io  = (k >= 11) && (k <= 19);
      phi = (k >= 13) && (k <= 17);
      oe  = (k >= 23) || ((k <= 5) && !m_first);
      rdy = (k >= 24) || (k == 0);
      return {rdy, be, bv, io, phi, phi, oe, (k == 0), 1'b1};
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Advance one cycle and compare the DUT against the model and invariants
   task automatic tick();
      logic [8:0] exp;
      @(negedge clk);
      if (m_valid) begin
         exp = expect_out();
         n_tests++;
         if (w_dut !== exp) begin
            n_fail++;
            $display("FAIL model_cycle count=%0d halt=%0b: got %b, expected %b",
                     m_count, m_halt, w_dut, exp);
         end
         n_tests++;
         if ((cpu_be_o && wb_addr_oe_o) || (io_valid_o && !bus_valid_o) ||
             (cpu_clock_o && !cpu_be_o)) begin
            n_fail++;
            $display("FAIL invariant: got outputs %b, required be/oe exclusive, io->bv, phi->be", w_dut);
         end
      end
   endtask

   // Called with reset asserted: checks cleared outputs, releases, times first period
   task automatic release_check();
      int first_be = -1, first_clk = -1, last_clk = -1, clk_cnt = 0;
      check("reset_outputs", int'(w_dut), 0);
      rst = 1'b0;
      for (int t = 1; t < 64; t++) begin
         tick();
         if (cpu_be_o && first_be < 0) first_be = t;
         if (cpu_clock_o) begin
            if (first_clk < 0) first_clk = t;
            last_clk = t;
            clk_cnt++;
         end
      end
      check("release_be_rise", first_be, 6);
      check("release_phi2_rise", first_clk, 13);
      check("release_phi2_last", last_clk, 17);
      check("release_phi2_width", clk_cnt, 5);
   endtask

   // Sync to a period start, then measure that whole period
   task automatic measure(input int sw_at, input logic [1:0] sw_spd,
                          output int len, output int rdy, output int phi, output int be);
      int guard = 0;
      len = 0; rdy = 0; phi = 0; be = 0;
      while (!period_start_o && guard < 300) begin
         tick();
         guard++;
      end
      if (guard >= 300) begin
         check("period_start_timeout", 0, 1);
         return;
      end
      do begin
         rdy += int'(wb_ready_o);
         phi += int'(cpu_clock_o);
         be  += int'(cpu_be_o);
         len++;
         if (len == sw_at) cpu_speed_i = sw_spd;
         tick();
      end while (!period_start_o && len < 300);
   endtask

   int len, rdy, phi, be, guard;

   initial begin
      rst = 1'b1; cpu_speed_i = 2'b00; cpu_halt_i = 1'b0;
      repeat (3) tick();
      release_check();

      // Reset in the middle of the Phi2 high phase
      guard = 0;
      while (!cpu_clock_o && guard < 200) begin tick(); guard++; end
      check("find_phi2_high", int'(cpu_clock_o), 1);
      rst = 1'b1;
      tick();
      check("reset_mid_phi2", int'(cpu_clock_o), 0);
      tick(); tick();
      release_check();

      // 1 MHz steady state
      measure(-1, 2'b00, len, rdy, phi, be);
      check("p64_len", len, 64);
      check("p64_ready", rdy, 41);
      check("p64_phi2", phi, 5);
      check("p64_be", be, 14);

      // 2 MHz: takes effect one period after the request
      cpu_speed_i = 2'b01;
      measure(-1, 2'b00, len, rdy, phi, be);
      measure(-1, 2'b00, len, rdy, phi, be);
      check("p32_len", len, 32);
      check("p32_ready", rdy, 9);
      check("p32_phi2", phi, 5);

      // Mid-period switch to 500 kHz does not stretch the current period
      cpu_speed_i = 2'b00;
      measure(-1, 2'b00, len, rdy, phi, be);
      check("p32_to_64_len", len, 32);
      measure(30, 2'b10, len, rdy, phi, be);
      check("midchange_len", len, 64);
      measure(-1, 2'b00, len, rdy, phi, be);
      check("p128_len", len, 128);
      check("p128_ready", rdy, 105);
      cpu_speed_i = 2'b00;
      measure(-1, 2'b00, len, rdy, phi, be);

      // Halt one period, then resume
      cpu_halt_i = 1'b1;
      measure(-1, 2'b00, len, rdy, phi, be);
      check("prehalt_phi2", phi, 5);
      cpu_halt_i = 1'b0;
      measure(-1, 2'b00, len, rdy, phi, be);
      check("halt_len", len, 64);
      check("halt_ready", rdy, 64);
      check("halt_phi2", phi, 0);
      check("halt_be", be, 0);
      measure(-1, 2'b00, len, rdy, phi, be);
      check("resume_ready", rdy, 41);
      check("resume_phi2", phi, 5);

      // Randomised speed/halt changes and occasional resets
      for (int i = 0; i < 6000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (rst) begin
            if (r < 400) rst = 1'b0;
         end else if (r < 2) begin
            rst = 1'b1;
         end else if (r < 30) begin
            cpu_speed_i = 2'($urandom_range(0, 3));
         end else if (r < 50) begin
            cpu_halt_i = 1'($urandom_range(0, 1));
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_bus_sequencer
`default_nettype wire
